spi_flash_burst_reader: RTL

//  Parametrised SPI (mode 0) flash read engine. It replaces the single-byte spi_flash_controller.
//  A read runs as one chip-select window: opcode, address, optional dummy byte, then 1..2^LEN_W bytes.
//  It also adds a start/busy/valid/done handshake, abort, and a programmable SCK divider.
//  It sits between the bus decoder (ROM/boot-loader fetch at clk = 44.33 MHz) and the external SPI flash.

---
 rtl/spi_flash_pkg.sv | 21 ++
 rtl/spi_flash_burst_reader_if.sv | 32 +++
 rtl/spi_sck_gen.sv | 49 ++++
 rtl/spi_flash_burst_reader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash burst reader.
//   OP_READ / OP_FAST_READ : flash read opcodes (slow read, fast read with dummy byte)
//   DUMMY_BITS             : SCK cycles in the fast-read dummy phase
//   state_t                : reader FSM state encoding
package spi_flash_pkg;

    localparam logic [7:0]  OP_READ      = 8'h03;
    localparam logic [7:0]  OP_FAST_READ = 8'h0B;
    localparam int unsigned DUMMY_BITS   = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StTail,   // last byte sampled: let SCK fall, then release CS
        StGap     // CS high, still busy
    } state_t;

endpackage

// File: rtl/spi_flash_burst_reader_if.sv
// Bus between the fetch logic / external flash and spi_flash_burst_reader.
//   start, addr, len, abort : request side (addr/len captured with an accepted start)
//   busy, data, valid, done : status and read data back to the requester
//   spi_clk, spi_mosi, spi_cs, spi_miso : SPI mode-0 pins
// Modports: slave = the reader; master = everything around it (requester and flash pins).
interface spi_flash_burst_reader_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;
    logic [7:0]        data;
    logic              valid;
    logic              done;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_cs;
    logic              spi_miso;

    modport slave (
        input  start, addr, len, abort, spi_miso,
        output busy, data, valid, done, spi_clk, spi_mosi, spi_cs
    );

    modport master (
        output start, addr, len, abort, spi_miso,
        input  busy, data, valid, done, spi_clk, spi_mosi, spi_cs
    );
endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: toggles sck every CLK_DIV clk cycles while en is high.
//   clk, rst_n : clock, async active-low reset
//   en         : run the divider
//   clr        : force sck low and restart the divider (has priority over en)
//   sck        : serial clock, idle low
//   rise, fall : one-clk strobes in the cycle whose clock edge makes sck rise / fall
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam int unsigned      CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0]  CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            sck_q;
    logic            tick;

    // Strobes do not depend on clr so the FSM can use them to decide clr.
    assign tick = en && (cnt_q == CntLast);
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;
    assign sck  = sck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt_q <= '0;
                sck_q <= ~sck_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end
endmodule

// File: rtl/spi_flash_burst_reader.sv
// SPI mode-0 flash burst read engine: one CS window carries opcode, address, optional
// dummy byte and len+1 data bytes.
//   clk, rst_n : clock, async active-low reset
//   bus        : request/status handshake and SPI pins (spi_flash_burst_reader_if.slave)
// ADDR_W must be a multiple of 8 in 8..32; CLK_DIV >= 1; CS_IDLE >= 1.
module spi_flash_burst_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          FAST_READ = 1'b0,
    parameter int unsigned CS_IDLE   = 2
) (
    input logic clk,
    input logic rst_n,
    spi_flash_burst_reader_if.slave bus
);
    localparam logic [7:0] Opcode = FAST_READ ? OP_FAST_READ : OP_READ;
    // busy drops in the last CS-high cycle so a back-to-back start leaves CS high
    // for exactly CS_IDLE clks; GAP therefore lasts CS_IDLE-1 clks.
    localparam bit               HasGap    = (CS_IDLE > 1);
    localparam int unsigned      GapW      = (CS_IDLE > 2) ? $clog2(CS_IDLE - 1) : 1;
    localparam logic [GapW-1:0]  GapLast   = GapW'(HasGap ? CS_IDLE - 2 : 0);
    localparam state_t           AfterStop = HasGap ? StGap : StIdle;
    localparam state_t           AfterAddr = FAST_READ ? StDummy : StData;

    state_t           state_q, state_d;
    logic [39:0]      sout_q, sout_d;
    logic [7:0]       sin_q, sin_d;
    logic [5:0]       bit_q, bit_d;
    logic [LEN_W:0]   byte_q, byte_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             cs_q, cs_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             active, sck_clr, sck_rise, sck_fall;

    assign active = state_q inside {StCmd, StAddr, StDummy, StData, StTail};

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (active),
        .clr  (sck_clr),
        .sck  (bus.spi_clk),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_comb begin
        state_d = state_q;
        sout_d  = sout_q;
        sin_d   = sin_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        len_d   = len_q;
        gap_d   = gap_q;
        cs_d    = cs_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        sck_clr = 1'b0;

        // Zeros shift in behind the header, so MOSI is 0 in DUMMY and DATA.
        if (active && sck_fall) sout_d = sout_q << 1;
        if (active && sck_rise) sin_d = {sin_q[6:0], bus.spi_miso};

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StCmd;
                    cs_d    = 1'b0;
                    sout_d  = (40'(Opcode) << 32) | (40'(bus.addr) << (32 - ADDR_W));
                    len_d   = bus.len;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            StCmd: if (sck_rise) begin
                if (bit_q == 6'd7) begin
                    bit_d   = '0;
                    state_d = StAddr;
                end else bit_d = bit_q + 6'd1;
            end
            StAddr: if (sck_rise) begin
                if (bit_q == 6'(ADDR_W - 1)) begin
                    bit_d   = '0;
                    state_d = AfterAddr;
                end else bit_d = bit_q + 6'd1;
            end
            StDummy: if (sck_rise) begin
                if (bit_q == 6'(DUMMY_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = StData;
                end else bit_d = bit_q + 6'd1;
            end
            StData: if (sck_rise) begin
                if (bit_q[2:0] == 3'd7) begin
                    bit_d   = '0;
                    data_d  = sin_d;
                    valid_d = 1'b1;
                    if (byte_q == {1'b0, len_q}) state_d = StTail;
                    else                         byte_d  = byte_q + 1'b1;
                end else bit_d = bit_q + 6'd1;
            end
            StTail: begin
                // valid_q here can only be the last byte's strobe.
                done_d = valid_q;
                // SCK already fell; the would-be next rise marks CS release.
                if (sck_rise) begin
                    sck_clr = 1'b1;
                    cs_d    = 1'b1;
                    sout_d  = '0;
                    gap_d   = '0;
                    state_d = AfterStop;
                end
            end
            StGap: begin
                if (gap_q == GapLast) state_d = StIdle;
                else                  gap_d   = gap_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (bus.abort && active) begin
            sck_clr = 1'b1;
            cs_d    = 1'b1;
            sout_d  = '0;
            gap_d   = '0;
            data_d  = data_q;
            valid_d = 1'b0;
            done_d  = 1'b0;
            state_d = AfterStop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sout_q  <= '0;
            sin_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            cs_q    <= 1'b1;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sout_q  <= sout_d;
            sin_q   <= sin_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            cs_q    <= cs_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.data     = data_q;
    assign bus.valid    = valid_q;
    assign bus.done     = done_q;
    assign bus.spi_cs   = cs_q;
    assign bus.spi_mosi = sout_q[39];
endmodule
